instruction_assembler: RTL and testbench
========================================

// Module: instruction_assembler
// PURPOSE
//  - Inverse of the field decoder: packs opcode/rd/func3/rs1/rs2/func7/imm into a 32-bit RV32I word.
//  - Encodes R, I, S, SB, U and UJ formats.
//  - Writes each word sequentially into instruction memory through a req/ack write port.
//  - Used by the lab testbench/loader to build programs in IMEM from field-level stimulus.
// PARAMETERS
//  - BASE_ADDR  32'h0000_0000  byte address of the first word written
//  - DEPTH      64             max words before FULL; power of 2, >=2
// PORTS
//  - clk        in   1   single clock, rising edge
//  - reset      in   1   asynchronous, active-high; all state to reset values
//  - clr        in   1   synchronous restart: addr=BASE_ADDR, count=0, err=0, state IDLE
//  - in_valid   in   1   field bundle valid
//  - in_ready   out  1   high only in IDLE; transfer when in_valid&&in_ready
//  - opcode     in   7   RV32I opcode
//  - rd         in   5   destination register
//  - func3      in   3   function field
//  - rs1        in   5   source register 1
//  - rs2        in   5   source register 2
//  - func7      in   7   R-type function field
//  - imm        in   32  immediate, byte offset, sign-extended by the source
//  - mem_we     out  1   write request, held until mem_ack
//  - mem_addr   out  32  byte address = BASE_ADDR + 4*count
//  - mem_wdata  out  32  encoded instruction
//  - mem_ack    in   1   write accepted this cycle
//  - count      out  $clog2(DEPTH)+1  words written
//  - full       out  1   count==DEPTH
//  - err        out  1   sticky: illegal opcode seen
// BEHAVIOUR
//  - Reset values: in_ready=0 during reset, 1 in the first cycle after it. mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0.
//  - FSM states: IDLE, ENC, WR, FULL.
//  - IDLE: in_ready=1. On a transfer, register all fields, then go to ENC.
//  - ENC: one cycle. Encode the registered fields into mem_wdata.
//    - Legal opcode -> WR.
//    - Illegal opcode -> set err, no write, count unchanged -> IDLE.
//  - WR: mem_we=1; mem_addr and mem_wdata stable until mem_ack.
//    - On mem_ack: mem_we=0 next cycle, count+=1, mem_addr+=4.
//    - Then go to FULL if the new count==DEPTH, else IDLE.
//  - FULL: in_ready=0 and full=1. Leave only via clr or reset.
//  - Latency: accept -> mem_we asserted 2 cycles later. Best-case throughput is one word per 3 cycles.
//  - Encoding:
//    - R  0110011: {func7,rs2,rs1,func3,rd,op}
//    - I  0010011/0000011/1100111/1110011: {imm[11:0],rs1,func3,rd,op}
//    - S  0100011: {imm[11:5],rs2,rs1,func3,imm[4:0],op}
//    - SB 1100011: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],op}
//    - U  0110111/0010111: {imm[31:12],rd,op}
//    - UJ 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//  - Fields unused by a format are ignored. Lost immediate bits (imm[0] of SB/UJ, imm[11:0] of U) are not errors.
//  - clr has priority over everything except reset, in any state.
//    - In WR it abandons the write: mem_we drops next cycle and a concurrent mem_ack is ignored.
//  - A transfer coincident with clr is dropped; in_ready is 1 on the cycle after clr.
//  - mem_addr arithmetic is 32-bit modulo; no wrap check beyond DEPTH.
// CONFIGURATION
//  - INSTR_ASM_CHECKSUM_EN defined:
//    - adds output `checksum` (32 bits): XOR of every acknowledged mem_wdata.
//    - reset and clr set it to 0; it updates in the same cycle count increments.
//  - Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared package rv32i_pkg: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL) and the FSM state encoding.
//  - One combinational sub-module, rv32i_field_encoder: (fields, imm) -> {word, legal}.
//  - Top level holds the FSM, counters, and the write port.
// TESTING
//  - add x3,x1,x2 (op 0110011, f3 0, f7 0) -> mem_wdata 0x002081B3 at addr 0x0, count=1.
//  - addi x1,x0,5 then sw x2,8(x1) -> 0x00500093 at 0x0, 0x0020A423 at 0x4.
//  - beq x1,x2,imm=-4; lui x5,imm=0x12345000; jal x1,imm=8 -> 0xFE208EE3, 0x123452B7, 0x008000EF.
//  - opcode 7'h7F -> err=1, mem_we never asserted, count unchanged; next legal word still written.
//  - mem_ack held low 5 cycles -> mem_we/addr/wdata stable throughout. clr in WR -> no count increment, addr=BASE_ADDR.
//  - DEPTH=4: 4 writes -> full=1, in_ready=0, 5th bundle not accepted. clr -> in_ready=1, count=0. Async reset mid-WR -> immediate reset values.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes and the assembler FSM state encoding.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_WR,
        ST_FULL
    } asm_state_t;

endpackage

// File: rtl/rv32i_field_encoder.sv
// Combinational RV32I packer: field bundle plus immediate -> 32-bit word and legal flag.
module rv32i_field_encoder
    import rv32i_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_func3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_func7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Unknown opcodes yield a zero word; the caller never writes it.
    always_comb begin
        o_word  = 32'h0;
        o_legal = 1'b1;
        case (i_opcode)
            OP_R:
                o_word = {i_func7, i_rs2, i_rs1, i_func3, i_rd, i_opcode};
            OP_IMM, OP_LOAD, OP_JALR, OP_SYS:
                o_word = {i_imm[11:0], i_rs1, i_func3, i_rd, i_opcode};
            OP_STORE:
                o_word = {i_imm[11:5], i_rs2, i_rs1, i_func3, i_imm[4:0], i_opcode};
            OP_BRANCH:
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_func3,
                          i_imm[4:1], i_imm[11], i_opcode};
            OP_LUI, OP_AUIPC:
                o_word = {i_imm[31:12], i_rd, i_opcode};
            OP_JAL:
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            default:
                o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_assembler.sv
// Packs field bundles into RV32I words and writes them sequentially to IMEM over a req/ack port.
// Optional: define INSTR_ASM_CHECKSUM_EN to add o_checksum (XOR of all acknowledged words).
module instruction_assembler
    import rv32i_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clr,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [6:0]               i_opcode,
    input  logic [4:0]               i_rd,
    input  logic [2:0]               i_func3,
    input  logic [4:0]               i_rs1,
    input  logic [4:0]               i_rs2,
    input  logic [6:0]               i_func7,
    input  logic [31:0]              i_imm,
    output logic                     o_mem_we,
    output logic [31:0]              o_mem_addr,
    output logic [31:0]              o_mem_wdata,
    input  logic                     i_mem_ack,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
`ifdef INSTR_ASM_CHECKSUM_EN
    output logic [31:0]              o_checksum,
`endif
    output logic                     o_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    asm_state_t r_state;
    asm_state_t w_next_state;

    logic [6:0]    r_opcode;
    logic [4:0]    r_rd;
    logic [2:0]    r_func3;
    logic [4:0]    r_rs1;
    logic [4:0]    r_rs2;
    logic [6:0]    r_func7;
    logic [31:0]   r_imm;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic [31:0]   w_word;
    logic          w_legal;
    logic          w_transfer;
    logic          w_ack;
    logic [CW-1:0] w_count_next;

    rv32i_field_encoder u_encoder (
        .i_opcode (r_opcode),
        .i_rd     (r_rd),
        .i_func3  (r_func3),
        .i_rs1    (r_rs1),
        .i_rs2    (r_rs2),
        .i_func7  (r_func7),
        .i_imm    (r_imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_transfer   = i_in_valid && o_in_ready && !i_clr;
    assign w_ack        = (r_state == ST_WR) && i_mem_ack && !i_clr;
    assign w_count_next = r_count + 1'b1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_transfer) w_next_state = ST_ENC;
            ST_ENC:  w_next_state = w_legal ? ST_WR : ST_IDLE;
            ST_WR:   if (i_mem_ack) w_next_state = (w_count_next == DEPTH_C) ? ST_FULL : ST_IDLE;
            ST_FULL: w_next_state = ST_FULL;
            default: w_next_state = ST_IDLE;
        endcase
        if (i_clr) begin
            w_next_state = ST_IDLE;
        end
    end

    // clr restarts the program but leaves the last encoded word and latched fields alone.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_opcode <= '0;
            r_rd     <= '0;
            r_func3  <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_func7  <= '0;
            r_imm    <= '0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else if (i_clr) begin
            r_addr   <= BASE_ADDR;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_opcode <= i_opcode;
                r_rd     <= i_rd;
                r_func3  <= i_func3;
                r_rs1    <= i_rs1;
                r_rs2    <= i_rs2;
                r_func7  <= i_func7;
                r_imm    <= i_imm;
            end
            if (r_state == ST_ENC) begin
                if (w_legal) begin
                    r_wdata <= w_word;
                end else begin
                    r_err   <= 1'b1;
                end
            end
            if (w_ack) begin
                r_count <= w_count_next;
                r_addr  <= r_addr + 32'd4;
            end
        end
    end

`ifdef INSTR_ASM_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_checksum <= '0;
        end else if (i_clr) begin
            r_checksum <= '0;
        end else if (w_ack) begin
            r_checksum <= r_checksum ^ r_wdata;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_in_ready  = (r_state == ST_IDLE) && !i_reset;
    assign o_mem_we    = (r_state == ST_WR);
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_count     = r_count;
    assign o_full      = (r_count == DEPTH_C);
    assign o_err       = r_err;

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed self-checking bench for instruction_assembler (DEPTH=4, BASE_ADDR=0).
module tb_instruction_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        inValid;
    logic        inReady;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck;
    logic [2:0]  count;
    logic        full;
    logic        err;
`ifdef INSTR_ASM_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    instruction_assembler #(
        .BASE_ADDR (32'h0000_0000),
        .DEPTH     (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clr       (clr),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_opcode    (opcode),
        .i_rd        (rd),
        .i_func3     (func3),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .i_func7     (func7),
        .i_imm       (imm),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .i_mem_ack   (memAck),
        .o_count     (count),
        .o_full      (full),
`ifdef INSTR_ASM_CHECKSUM_EN
        .o_checksum  (checksum),
`endif
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic setFields(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                             input logic [31:0] im);
        opcode = op; rd = d; func3 = f3; rs1 = s1; rs2 = s2; func7 = f7; imm = im;
    endtask

    // Returns on the negedge right after the accepting clock edge.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                                 input logic [31:0] im);
        int waitCnt = 0;
        @(negedge clk);
        setFields(op, d, f3, s1, s2, f7, im);
        inValid = 1'b1;
        while (!inReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept", {31'b0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic waitWrite(input string tag);
        int waitCnt = 0;
        while (!memWe && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput(tag, {31'b0, memWe}, 32'd1);
    endtask

    task automatic expectWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        waitWrite({tag, "_we"});
        checkOutput({tag, "_addr"}, memAddr, addr);
        checkOutput({tag, "_data"}, memWdata, data);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checkOutput({tag, "_we_drop"}, {31'b0, memWe}, 32'd0);
    endtask

    task automatic pulseClr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; inValid = 1'b0; memAck = 1'b0;
        setFields(7'h0, 5'h0, 3'h0, 5'h0, 5'h0, 7'h0, 32'h0);

        @(negedge clk);
        checkOutput("rst_ready", {31'b0, inReady}, 32'd0);
        checkOutput("rst_we", {31'b0, memWe}, 32'd0);
        checkOutput("rst_addr", memAddr, 32'h0);
        checkOutput("rst_wdata", memWdata, 32'h0);
        checkOutput("rst_count", {29'b0, count}, 32'd0);
        checkOutput("rst_full", {31'b0, full}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", {31'b0, inReady}, 32'd1);

        // add x3,x1,x2 with latency check
        applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        checkOutput("lat_enc_we", {31'b0, memWe}, 32'd0);
        checkOutput("lat_enc_ready", {31'b0, inReady}, 32'd0);
        @(negedge clk);
        checkOutput("lat_wr_we", {31'b0, memWe}, 32'd1);
        expectWrite("add", 32'h0, 32'h002081B3);
        checkOutput("add_count", {29'b0, count}, 32'd1);
        checkOutput("add_ready", {31'b0, inReady}, 32'd1);
`ifdef INSTR_ASM_CHECKSUM_EN
        checkOutput("add_checksum", checksum, 32'h002081B3);
`endif
        pulseClr();
        checkOutput("clr1_count", {29'b0, count}, 32'd0);
        checkOutput("clr1_addr", memAddr, 32'h0);
`ifdef INSTR_ASM_CHECKSUM_EN
        checkOutput("clr1_checksum", checksum, 32'h0);
`endif

        // addi x1,x0,5 then sw x2,8(x1)
        applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        expectWrite("addi", 32'h0, 32'h00500093);
        applyStimulus(7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        expectWrite("sw", 32'h4, 32'h0020A423);
        checkOutput("sw_count", {29'b0, count}, 32'd2);
        pulseClr();

        // beq, lui, jal, then illegal, then fourth word fills memory
        applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        expectWrite("beq", 32'h0, 32'hFE208EE3);
        applyStimulus(7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
        expectWrite("lui", 32'h4, 32'h123452B7);
        applyStimulus(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        expectWrite("jal", 32'h8, 32'h008000EF);
        checkOutput("jal_count", {29'b0, count}, 32'd3);

        applyStimulus(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("illegal_no_we", {31'b0, memWe}, 32'd0);
            @(negedge clk);
        end
        checkOutput("illegal_err", {31'b0, err}, 32'd1);
        checkOutput("illegal_count", {29'b0, count}, 32'd3);

        applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        expectWrite("add4", 32'hC, 32'h002081B3);
        checkOutput("full_count", {29'b0, count}, 32'd4);
        checkOutput("full_flag", {31'b0, full}, 32'd1);
        checkOutput("full_ready", {31'b0, inReady}, 32'd0);
        checkOutput("err_sticky", {31'b0, err}, 32'd1);

        setFields(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("full_block_ready", {31'b0, inReady}, 32'd0);
            checkOutput("full_block_we", {31'b0, memWe}, 32'd0);
        end
        inValid = 1'b0;
        checkOutput("full_block_count", {29'b0, count}, 32'd4);

        pulseClr();
        checkOutput("clr2_ready", {31'b0, inReady}, 32'd1);
        checkOutput("clr2_count", {29'b0, count}, 32'd0);
        checkOutput("clr2_full", {31'b0, full}, 32'd0);
        checkOutput("clr2_err", {31'b0, err}, 32'd0);
        checkOutput("clr2_addr", memAddr, 32'h0);

        // ack held off for five cycles: write port must stay stable
        applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        waitWrite("stall_we");
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_hold_we", {31'b0, memWe}, 32'd1);
            checkOutput("stall_hold_addr", memAddr, 32'h0);
            checkOutput("stall_hold_data", memWdata, 32'h00500093);
            @(negedge clk);
        end
        expectWrite("stall", 32'h0, 32'h00500093);
        checkOutput("stall_count", {29'b0, count}, 32'd1);

        // clr during WR with concurrent ack abandons the write
        applyStimulus(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        waitWrite("clrwr_we");
        checkOutput("clrwr_addr_before", memAddr, 32'h4);
        clr = 1'b1;
        memAck = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        memAck = 1'b0;
        checkOutput("clrwr_we", {31'b0, memWe}, 32'd0);
        checkOutput("clrwr_count", {29'b0, count}, 32'd0);
        checkOutput("clrwr_addr", memAddr, 32'h0);
        checkOutput("clrwr_ready", {31'b0, inReady}, 32'd1);

        // async reset in the middle of a pending write
        applyStimulus(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
        expectWrite("jal2", 32'h0, 32'h008000EF);
        applyStimulus(7'b0100011, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
        waitWrite("arst_we_before");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_we", {31'b0, memWe}, 32'd0);
        checkOutput("arst_addr", memAddr, 32'h0);
        checkOutput("arst_wdata", memWdata, 32'h0);
        checkOutput("arst_count", {29'b0, count}, 32'd0);
        checkOutput("arst_ready", {31'b0, inReady}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("arst_release_ready", {31'b0, inReady}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
